// File: rtl/dbus_responder_pkg.sv
// Shared data-bus types and responder constants.
// DBUS_POISON is returned for out-of-range reads when DBUS_RESP_RANGE_CHECK_EN is defined.
package dbus_responder_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  localparam logic [63:0] DBUS_POISON = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dbus_resp_state_t;

  // Word offset of a byte address relative to the mapped base (wraps below base).
  function automatic logic [63:0] dbus_word_off(input logic [63:0] addr,
                                                input logic [63:0] base);
    logic [63:0] diff;
    diff = addr - base;
    return diff >> 3;
  endfunction

endpackage

// File: rtl/dbus_resp_ram.sv
// MEM_WORDS x 64-bit RAM: one registered read port, one byte-strobed write port, no reset.
module dbus_resp_ram #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_idx_i,
  output logic [63:0]   rd_data_o,
  input  logic [7:0]    wr_strb_i,
  input  logic [AW-1:0] wr_idx_i,
  input  logic [63:0]   wr_data_i
);

  logic [63:0] mem_q [MEM_WORDS];
  logic [63:0] rd_data_q;

  // Read register only updates when enabled, so it holds the last fetched word.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  // Byte-lane write; lanes with a clear strobe keep their old contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (wr_strb_i[i]) begin
        mem_q[wr_idx_i][8*i +: 8] <= wr_data_i[8*i +: 8];
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder: fixed-latency addr_ok/data_ok handshake in front of a byte-writable RAM.
// Optional DBUS_RESP_RANGE_CHECK_EN: out-of-range reads return DBUS_POISON and
// out-of-range writes are dropped; otherwise addresses wrap modulo MEM_WORDS.
//
// state | meaning
// IDLE  | ready; addr_ok follows dreq.valid, request latched on accept
// WAIT  | counting down latency, dreq ignored
// RESP  | data_ok high for one cycle; pending write commits on the closing edge
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int unsigned AW       = $clog2(MEM_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam bit          LAT_ONE  = (LATENCY == 1);

  dbus_resp_state_t state_q;
  logic [3:0]       cnt_q;
  logic [63:0]      addr_q;
  logic [63:0]      wdata_q;
  logic [7:0]       strb_q;
  logic             data_ok_q;
  logic             data_vld_q;
  logic             poison_q;

  logic [63:0]      rd_addr;
  logic [AW-1:0]    rd_idx;
  logic [AW-1:0]    wr_idx;
  logic             rd_en;
  logic [7:0]       wr_strb;
  logic [63:0]      ram_rd_data;
  logic             rd_poison;
  logic             wr_drop;
  logic [2:0]       unused_size;

  assign unused_size = dreq.size;

  // With LATENCY==1 the read is launched straight from the incoming request.
  assign rd_addr = (state_q == IDLE) ? dreq.addr : addr_q;
  assign rd_idx  = AW'(dbus_word_off(rd_addr, BASE_ADDR));
  assign wr_idx  = AW'(dbus_word_off(addr_q, BASE_ADDR));

  // The RAM read fires on exactly the edge that enters RESP.
  assign rd_en = reset &&
                 (((state_q == IDLE) && dreq.valid && LAT_ONE) ||
                  ((state_q == WAIT) && (cnt_q == 4'd1)));

`ifdef DBUS_RESP_RANGE_CHECK_EN
  assign rd_poison = (rd_addr < BASE_ADDR) ||
                     (dbus_word_off(rd_addr, BASE_ADDR) >= 64'(MEM_WORDS));
  assign wr_drop   = (addr_q < BASE_ADDR) ||
                     (dbus_word_off(addr_q, BASE_ADDR) >= 64'(MEM_WORDS));
`else
  assign rd_poison = 1'b0;
  assign wr_drop   = 1'b0;
`endif

  // Write commits on the edge closing RESP, so RESP still returns the pre-write word;
  // reset on that edge drops the write.
  assign wr_strb = ((state_q == RESP) && reset && !wr_drop) ? strb_q : 8'h00;

  dbus_resp_ram #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_ram (
    .clk       (clk),
    .rd_en_i   (rd_en),
    .rd_idx_i  (rd_idx),
    .rd_data_o (ram_rd_data),
    .wr_strb_i (wr_strb),
    .wr_idx_i  (wr_idx),
    .wr_data_i (wdata_q)
  );

  // Handshake FSM, latency counter and registered response flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_ok_q  <= 1'b0;
      data_vld_q <= 1'b0;
      poison_q   <= 1'b0;
    end else begin
      data_ok_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dreq.valid) begin
            addr_q  <= dreq.addr;
            strb_q  <= dreq.strobe;
            wdata_q <= dreq.data;
            cnt_q   <= CNT_INIT;
            if (LAT_ONE) begin
              state_q    <= RESP;
              data_ok_q  <= 1'b1;
              data_vld_q <= 1'b1;
              poison_q   <= rd_poison;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q    <= RESP;
            data_ok_q  <= 1'b1;
            data_vld_q <= 1'b1;
            poison_q   <= rd_poison;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // addr_ok is combinational from IDLE; data is zero until the first response after reset.
  always_comb begin
    dresp         = '0;
    dresp.addr_ok = reset && (state_q == IDLE) && dreq.valid;
    dresp.data_ok = data_ok_q;
    if (data_vld_q) begin
      dresp.data = poison_q ? DBUS_POISON : ram_rd_data;
    end
  end

endmodule

// File: tb/tb_dbus_responder.sv
// Randomized bench for dbus_responder with LATENCY 2, 1 and 7 instances and a word-map model.
module tb_dbus_responder;
  import dbus_responder_pkg::*;

  localparam int unsigned MEM_WORDS = 4096;
  localparam logic [63:0] BASE      = 64'h8000_0000;
`ifdef DBUS_RESP_RANGE_CHECK_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  dreq  [3];
  dbus_resp_t dresp [3];

  int n_checks = 0;
  int n_errors = 0;

  // Expected memory: key = instance*MEM_WORDS + word; absent key = contents unknown.
  logic [63:0] mdl [int];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dbus_responder #(
      .MEM_WORDS (MEM_WORDS),
      .LATENCY   ((g == 0) ? 2 : ((g == 1) ? 1 : 7)),
      .BASE_ADDR (BASE)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .dreq  (dreq[g]),
      .dresp (dresp[g])
    );
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 7);
  endfunction

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (((a - BASE) / 8) < 64'(MEM_WORDS));
  endfunction

  function automatic int key_of(input int g, input logic [63:0] a);
    return g * MEM_WORDS + int'(((a - BASE) / 8) % 64'(MEM_WORDS));
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction; checks handshake timing and read data against the model.
  task automatic txn(input int g, input logic [63:0] addr, input logic [7:0] strb,
                     input logic [63:0] wdata, input bit drop_valid, input string tag,
                     output logic [63:0] rd_o);
    int          lat, ok_cyc, n_ok, n_aok, k;
    bit          known, oor;
    logic [63:0] old, exp_rd, nw;
    lat    = lat_of(g);
    k      = key_of(g, addr);
    oor    = RC_EN && !in_rng(addr);
    known  = mdl.exists(k);
    old    = known ? mdl[k] : 64'h0;
    exp_rd = oor ? DBUS_POISON : old;
    @(posedge clk); #1;
    dreq[g] = '{valid: 1'b1, addr: addr, size: 3'($urandom_range(0, 3)),
                strobe: strb, data: wdata};
    ok_cyc = -1; n_ok = 0; n_aok = 0; rd_o = '0;
    for (int c = 0; c <= lat + 2; c++) begin
      @(negedge clk);
      if (c == 0) chk({tag, "/addr_ok_c0"}, 64'(dresp[g].addr_ok), 64'd1);
      else if (dresp[g].addr_ok) n_aok++;
      if (dresp[g].data_ok) begin
        n_ok++;
        if (ok_cyc < 0) begin
          ok_cyc = c;
          rd_o   = dresp[g].data;
        end
        dreq[g].valid = 1'b0;
      end
      if (c == 1 && drop_valid) dreq[g].valid = 1'b0;
      if (c == lat + 2 && (known || oor)) chk({tag, "/data_hold"}, dresp[g].data, exp_rd);
    end
    dreq[g].valid = 1'b0;
    chk({tag, "/data_ok_cycle"}, 64'(ok_cyc), 64'(lat));
    chk({tag, "/data_ok_count"}, 64'(n_ok), 64'd1);
    chk({tag, "/addr_ok_extra"}, 64'(n_aok), 64'd0);
    if (known || oor) chk({tag, "/rdata"}, rd_o, exp_rd);
    if (strb != 8'h00 && !oor) begin
      if (known || strb == 8'hFF) begin
        nw = old;
        for (int i = 0; i < 8; i++) if (strb[i]) nw[8*i +: 8] = wdata[8*i +: 8];
        mdl[k] = nw;
      end else begin
        mdl.delete(k);
      end
    end
  endtask

  function automatic logic [63:0] pick_addr();
    int unsigned w, sel;
    logic [63:0] a;
    w   = $urandom_range(0, 7);
    sel = $urandom_range(0, 3);
    if (sel <= 1)      a = BASE + 64'(8 * w);
    else if (sel == 2) a = BASE + 64'(8 * (w + MEM_WORDS));
    else               a = BASE - 64'(8 * (w + 1));
    return a | 64'($urandom_range(0, 7));
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd, d1, d2, a;
    logic [7:0]  s;
    int          n_ok;
    int          aok_c[$];
    int          dok_c[$];

    reset = 1'b0;
    for (int g = 0; g < 3; g++) dreq[g] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset%0d/addr_ok", g), 64'(dresp[g].addr_ok), 64'd0);
      chk($sformatf("reset%0d/data_ok", g), 64'(dresp[g].data_ok), 64'd0);
      chk($sformatf("reset%0d/data", g), dresp[g].data, 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;

    // Write then read
    txn(0, 64'h8000_0010, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, "t1_st", rd);
    txn(0, 64'h8000_0010, 8'h00, 64'h0, 1'b0, "t1_ld", rd);
    chk("t1_value", rd, 64'h0123_4567_89AB_CDEF);

    // Byte strobe
    txn(0, 64'h8000_0020, 8'hFF, 64'h0, 1'b0, "t2_fill", rd);
    txn(0, 64'h8000_0020, 8'h0C, 64'h0000_0000_AABB_0000, 1'b0, "t2_st", rd);
    txn(0, 64'h8000_0020, 8'h00, 64'h0, 1'b0, "t2_ld", rd);
    chk("t2_value", rd, 64'h0000_0000_AABB_0000);

    // Latency sweep
    for (int g = 0; g < 3; g++) begin
      txn(g, BASE + 64'h100, 8'hFF, {$urandom, $urandom}, 1'b0, $sformatf("t3_st_l%0d", lat_of(g)), rd);
      txn(g, BASE + 64'h100, 8'h00, 64'h0, 1'b0, $sformatf("t3_ld_l%0d", lat_of(g)), rd);
    end

    // Reset mid-operation
    @(posedge clk); #1;
    dreq[0] = '{valid: 1'b1, addr: 64'h8000_0010, size: 3'd3, strobe: 8'h00, data: 64'h0};
    @(negedge clk);
    chk("t4_addr_ok_c0", 64'(dresp[0].addr_ok), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    dreq[0].valid = 1'b0;
    @(negedge clk);
    chk("t4_c1_addr_ok", 64'(dresp[0].addr_ok), 64'd0);
    chk("t4_c1_data_ok", 64'(dresp[0].data_ok), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    n_ok = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (dresp[0].data_ok) n_ok++;
      if (c == 0) begin
        chk("t4_post_data", dresp[0].data, 64'd0);
        chk("t4_post_addr_ok", 64'(dresp[0].addr_ok), 64'd0);
      end
    end
    chk("t4_no_data_ok", 64'(n_ok), 64'd0);
    txn(0, 64'h8000_0010, 8'h00, 64'h0, 1'b0, "t4_ld", rd);
    chk("t4_value", rd, 64'h0123_4567_89AB_CDEF);

    // Back-to-back with valid held high
    @(posedge clk); #1;
    dreq[0] = '{valid: 1'b1, addr: 64'h8000_0010, size: 3'd3, strobe: 8'h00, data: 64'h0};
    d1 = '0; d2 = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (dresp[0].addr_ok) aok_c.push_back(c);
      if (dresp[0].data_ok) begin
        dok_c.push_back(c);
        if (dok_c.size() == 1) begin
          d1 = dresp[0].data;
          dreq[0].addr = 64'h8000_0020;
        end else begin
          d2 = dresp[0].data;
          dreq[0].valid = 1'b0;
        end
      end
    end
    dreq[0].valid = 1'b0;
    chk("t5_addr_ok_n", 64'(aok_c.size()), 64'd2);
    chk("t5_data_ok_n", 64'(dok_c.size()), 64'd2);
    chk("t5_addr_ok2_cycle", 64'((aok_c.size() > 1) ? aok_c[1] : -1), 64'(lat_of(0) + 1));
    chk("t5_data_ok2_cycle", 64'((dok_c.size() > 1) ? dok_c[1] : -1), 64'(2 * lat_of(0) + 1));
    chk("t5_data1", d1, 64'h0123_4567_89AB_CDEF);
    chk("t5_data2", d2, 64'h0000_0000_AABB_0000);

    // Range / wrap behaviour
    txn(0, BASE, 8'hFF, 64'h1111_2222_3333_4444, 1'b0, "t6_st0", rd);
    txn(0, BASE + 64'(8 * MEM_WORDS), 8'h00, 64'h0, 1'b0, "t6_ld_hi", rd);
    chk("t6_hi_value", rd, RC_EN ? DBUS_POISON : 64'h1111_2222_3333_4444);
    txn(0, BASE + 64'(8 * MEM_WORDS), 8'hFF, 64'h5555_6666_7777_8888, 1'b0, "t6_st_hi", rd);
    txn(0, BASE, 8'h00, 64'h0, 1'b0, "t6_ld0", rd);
    chk("t6_word0", rd, RC_EN ? 64'h1111_2222_3333_4444 : 64'h5555_6666_7777_8888);
    txn(0, BASE + 64'(8 * (MEM_WORDS - 1)), 8'hFF, 64'h7777_0000_7777_0000, 1'b0, "t6_st_top", rd);
    txn(0, BASE - 64'd8, 8'h00, 64'h0, 1'b0, "t6_ld_lo", rd);
    chk("t6_lo_value", rd, RC_EN ? DBUS_POISON : 64'h7777_0000_7777_0000);

    // Randomized traffic on the LATENCY=2 and LATENCY=1 instances
    for (int g = 0; g < 2; g++) begin
      for (int w = 0; w < 8; w++) begin
        txn(g, BASE + 64'(8 * w), 8'hFF, {$urandom, $urandom}, 1'b0, "rnd_fill", rd);
        txn(g, BASE + 64'(8 * (MEM_WORDS - 1 - w)), 8'hFF, {$urandom, $urandom}, 1'b0, "rnd_fill", rd);
      end
      for (int n = 0; n < 30; n++) begin
        a = pick_addr();
        s = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        txn(g, a, s, {$urandom, $urandom}, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_%0d", g, n), rd);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
